// File: rtl/pong_pkg.sv
// pong_pkg: constants and types shared by the Pong input stage.
//   - Button bit indices (board button order on botoes_n / nivel / pulso / mover).
//   - Debounce FSM state encoding.
//   - Default timing constants, sized for a 50 MHz clock.
//   - max_u helper used to size the auto-repeat counter.
package pong_pkg;

    localparam int unsigned NUM_BOTOES = 6;
    localparam int unsigned NUM_PADDLE = 4;

    localparam int unsigned BTN_ESQ_CIMA  = 0;
    localparam int unsigned BTN_ESQ_BAIXO = 1;
    localparam int unsigned BTN_DIR_CIMA  = 2;
    localparam int unsigned BTN_DIR_BAIXO = 3;
    localparam int unsigned BTN_PAUSA     = 4;
    localparam int unsigned BTN_INICIAR   = 5;

    localparam int unsigned DEBOUNCE_CICLOS_PADRAO = 50000;     // 1 ms
    localparam int unsigned REPEAT_ATRASO_PADRAO   = 15000000;  // 300 ms
    localparam int unsigned REPEAT_PERIODO_PADRAO  = 5000000;   // 100 ms

    typedef enum logic [1:0] {
        StSolto         = 2'd0,
        StConfirmaPress = 2'd1,
        StPressionado   = 2'd2,
        StConfirmaSolta = 2'd3
    } estado_debounce_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_botao.sv
// debounce_botao: conditions one raw active-low pushbutton.
//   2-flop synchronizer (reset to released) followed by a debounce FSM that accepts a level
//   change only after DEBOUNCE_CICLOS consecutive agreeing samples.
// Ports:
//   clock, reset     system clock, asynchronous active-low reset
//   botao_n          raw button, active-low, asynchronous to clock
//   nivel            registered debounced level, active-high
//   pulso            registered one-cycle pulse on each accepted press
//   nivel_prox       value nivel takes at the next edge (lets the parent register outputs
//   pulso_prox       aligned with nivel/pulso)
module debounce_botao
    import pong_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
    input  logic clock,
    input  logic reset,
    input  logic botao_n,
    output logic nivel,
    output logic pulso,
    output logic nivel_prox,
    output logic pulso_prox
);

    localparam int unsigned  CW         = $clog2(DEBOUNCE_CICLOS + 1);
    localparam logic [CW-1:0] CNT_ULTIMO = CW'(DEBOUNCE_CICLOS - 1);

    logic [1:0]       sinc_q;
    logic             apertado;
    estado_debounce_t estado_q, estado_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             nivel_q, pulso_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sinc_q <= 2'b11;
        end else begin
            sinc_q <= {sinc_q[0], botao_n};
        end
    end

    assign apertado = ~sinc_q[1];

    // The counter holds the number of agreeing samples already seen in a CONFIRMA state; it is 0
    // in SOLTO/PRESSIONADO, so the first disagreeing sample counts as sample 1 (DEBOUNCE_CICLOS=1
    // accepts immediately). The >= keeps it saturating.
    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        unique case (estado_q)
            StSolto, StConfirmaPress: begin
                if (apertado) begin
                    if (cnt_q >= CNT_ULTIMO) begin
                        estado_d = StPressionado;
                        cnt_d    = '0;
                    end else begin
                        estado_d = StConfirmaPress;
                        cnt_d    = cnt_q + 1'b1;
                    end
                end else begin
                    estado_d = StSolto;
                    cnt_d    = '0;
                end
            end
            StPressionado, StConfirmaSolta: begin
                if (!apertado) begin
                    if (cnt_q >= CNT_ULTIMO) begin
                        estado_d = StSolto;
                        cnt_d    = '0;
                    end else begin
                        estado_d = StConfirmaSolta;
                        cnt_d    = cnt_q + 1'b1;
                    end
                end else begin
                    estado_d = StPressionado;
                    cnt_d    = '0;
                end
            end
            default: begin
                estado_d = StSolto;
                cnt_d    = '0;
            end
        endcase
    end

    assign nivel_prox = (estado_d == StPressionado) || (estado_d == StConfirmaSolta);
    assign pulso_prox = nivel_prox & ~nivel_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= StSolto;
            cnt_q    <= '0;
            nivel_q  <= 1'b0;
            pulso_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            nivel_q  <= nivel_prox;
            pulso_q  <= pulso_prox;
        end
    end

    assign nivel = nivel_q;
    assign pulso = pulso_q;

endmodule

// File: rtl/condicionador_botoes.sv
// condicionador_botoes: input-conditioning stage for the Pong board buttons.
//   Six debounce_botao instances give clean levels and press pulses; the four paddle bits also
//   get auto-repeat move pulses, suppressed while both buttons of the same paddle are held.
// Ports:
//   clock, reset   system clock, asynchronous active-low reset
//   botoes_n[5:0]  raw active-low buttons: esq_cima, esq_baixo, dir_cima, dir_baixo, pausa, iniciar
//   nivel[5:0]     debounced level, active-high
//   pulso[5:0]     one-cycle pulse per accepted press
//   mover[3:0]     paddle-move pulses (press + auto-repeat, conflict-suppressed)
module condicionador_botoes
    import pong_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO,
    parameter int unsigned REPEAT_ATRASO   = REPEAT_ATRASO_PADRAO,
    parameter int unsigned REPEAT_PERIODO  = REPEAT_PERIODO_PADRAO
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_BOTOES-1:0] botoes_n,
    output logic [NUM_BOTOES-1:0] nivel,
    output logic [NUM_BOTOES-1:0] pulso,
    output logic [NUM_PADDLE-1:0] mover
);

    localparam int unsigned   RW             = $clog2(max_u(REPEAT_ATRASO, REPEAT_PERIODO) + 1);
    localparam logic [RW-1:0] ATRASO_ULTIMO  = RW'(REPEAT_ATRASO - 1);
    localparam logic [RW-1:0] PERIODO_ULTIMO = RW'(REPEAT_PERIODO - 1);

    logic [NUM_BOTOES-1:0] nivel_prox, pulso_prox;
    logic                  unused_prox;

    for (genvar gi = 0; gi < NUM_BOTOES; gi++) begin : g_botao
        debounce_botao #(
            .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
        ) u_debounce (
            .clock     (clock),
            .reset     (reset),
            .botao_n   (botoes_n[gi]),
            .nivel     (nivel[gi]),
            .pulso     (pulso[gi]),
            .nivel_prox(nivel_prox[gi]),
            .pulso_prox(pulso_prox[gi])
        );
    end

    // pausa/iniciar have no move output.
    assign unused_prox = ^{nivel_prox[BTN_INICIAR], nivel_prox[BTN_PAUSA],
                           pulso_prox[BTN_INICIAR], pulso_prox[BTN_PAUSA]};

    // Index [0] is the left paddle, [1] the right one.
    logic [1:0]            conflito_d, conflito_q;
    logic [RW-1:0]         rep_cnt_q [NUM_PADDLE];
    logic [RW-1:0]         rep_cnt_d [NUM_PADDLE];
    logic [NUM_PADDLE-1:0] periodico_q, periodico_d;
    logic [NUM_PADDLE-1:0] mover_q, mover_d;

    // Computed from next-state levels so mover lines up with the registered pulso.
    assign conflito_d[0] = nivel_prox[BTN_ESQ_CIMA] & nivel_prox[BTN_ESQ_BAIXO];
    assign conflito_d[1] = nivel_prox[BTN_DIR_CIMA] & nivel_prox[BTN_DIR_BAIXO];

    // rep_cnt counts edges since the last move (or since the timing anchor); periodico selects
    // whether the next move is the first repeat (ATRASO) or a subsequent one (PERIODO).
    always_comb begin
        mover_d     = '0;
        periodico_d = periodico_q;
        for (int i = 0; i < NUM_PADDLE; i++) begin
            rep_cnt_d[i] = rep_cnt_q[i];
            // Timing anchor: released, in conflict, fresh press, or a conflict just ending (the
            // survivor restarts without an immediate move).
            if (!nivel_prox[i] || conflito_d[i/2] || pulso_prox[i] || conflito_q[i/2]) begin
                rep_cnt_d[i]   = '0;
                periodico_d[i] = 1'b0;
                mover_d[i]     = pulso_prox[i] & ~conflito_d[i/2];
            end else if (rep_cnt_q[i] >= (periodico_q[i] ? PERIODO_ULTIMO : ATRASO_ULTIMO)) begin
                rep_cnt_d[i]   = '0;
                periodico_d[i] = 1'b1;
                mover_d[i]     = 1'b1;
            end else begin
                rep_cnt_d[i]   = rep_cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            conflito_q  <= '0;
            periodico_q <= '0;
            mover_q     <= '0;
            for (int i = 0; i < NUM_PADDLE; i++) begin
                rep_cnt_q[i] <= '0;
            end
        end else begin
            conflito_q  <= conflito_d;
            periodico_q <= periodico_d;
            mover_q     <= mover_d;
            for (int i = 0; i < NUM_PADDLE; i++) begin
                rep_cnt_q[i] <= rep_cnt_d[i];
            end
        end
    end

    assign mover = mover_q;

endmodule

// File: tb/tb_condicionador_botoes.sv
// tb_condicionador_botoes: directed plus randomized stimulus against a behavioural model.
//   Model: the debouncer sees the raw input two edges late; a level is accepted when the last
//   DEBOUNCE_CICLOS samples agree. A paddle bit is "active" while held and its partner is not;
//   moves fire at the anchor (if it is a press) and at anchor+ATRASO+k*PERIODO.
module tb_condicionador_botoes;

    localparam int D = 4;
    localparam int A = 8;
    localparam int P = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] botoes_n;
    logic [5:0] nivel, pulso;
    logic [3:0] mover;

    always #5 clock = ~clock;

    condicionador_botoes #(
        .DEBOUNCE_CICLOS(D),
        .REPEAT_ATRASO  (A),
        .REPEAT_PERIODO (P)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .botoes_n(botoes_n),
        .nivel   (nivel),
        .pulso   (pulso),
        .mover   (mover)
    );

    int testes = 0;
    int falhas = 0;

    task automatic verificar(input string tag, input logic [31:0] obtido,
                             input logic [31:0] esperado);
        testes++;
        if (obtido !== esperado) begin
            falhas++;
            $display("FAIL %s @%0t: obtido=%0h esperado=%0h", tag, $time, obtido, esperado);
        end
    endtask

    // Behavioural model state.
    logic [5:0] raw_log [$];
    logic [5:0] amostras [$];
    logic [5:0] m_nivel, m_pulso;
    logic [3:0] m_mover;
    int         n_borda;
    int         ancora [4];
    bit         ativo_ant [4];

    task automatic modelo_reset();
        raw_log.delete();
        amostras.delete();
        m_nivel = '0;
        m_pulso = '0;
        m_mover = '0;
        n_borda = 0;
        for (int i = 0; i < 4; i++) begin
            ancora[i]    = 0;
            ativo_ant[i] = 1'b0;
        end
    endtask

    task automatic modelo_passo(input logic [5:0] raw);
        logic [5:0] s, ant;
        bit         unanime, at;
        int         d;
        raw_log.push_back(raw);
        if (raw_log.size() > 3) void'(raw_log.pop_front());
        s = (raw_log.size() == 3) ? ~raw_log[0] : 6'b0;
        amostras.push_back(s);
        if (amostras.size() > D) void'(amostras.pop_front());
        ant = m_nivel;
        if (amostras.size() == D) begin
            for (int b = 0; b < 6; b++) begin
                unanime = 1'b1;
                for (int j = 1; j < D; j++)
                    if (amostras[j][b] != amostras[0][b]) unanime = 1'b0;
                if (unanime) m_nivel[b] = amostras[0][b];
            end
        end
        m_pulso = m_nivel & ~ant;
        n_borda++;
        for (int i = 0; i < 4; i++) begin
            at = m_nivel[i] && !m_nivel[i ^ 1];
            if (at && !ativo_ant[i]) ancora[i] = n_borda;
            d = n_borda - ancora[i];
            m_mover[i] = at && ((d == 0 && m_pulso[i]) || (d >= A && (d - A) % P == 0));
            ativo_ant[i] = at;
        end
    endtask

    task automatic ciclo(input logic [5:0] raw);
        botoes_n = raw;
        @(posedge clock);
        modelo_passo(raw);
        @(negedge clock);
        verificar("nivel", nivel, m_nivel);
        verificar("pulso", pulso, m_pulso);
        verificar("mover", mover, m_mover);
    endtask

    task automatic aplicar_reset(input logic [5:0] raw);
        botoes_n = raw;
        reset    = 1'b0;
        #1;
        modelo_reset();
        verificar("reset_nivel", nivel, 32'd0);
        verificar("reset_pulso", pulso, 32'd0);
        verificar("reset_mover", mover, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    logic [5:0] cur;
    int         restante [6];

    initial begin
        reset    = 1'b0;
        botoes_n = '1;
        modelo_reset();
        repeat (2) @(negedge clock);
        verificar("por_nivel", nivel, 32'd0);
        verificar("por_mover", mover, 32'd0);
        reset = 1'b1;
        cur   = '1;
        repeat (3) ciclo(cur);

        // Clean press on pausa.
        cur[4] = 1'b0;
        repeat (20) ciclo(cur);
        cur[4] = 1'b1;
        repeat (10) ciclo(cur);

        // Bounce on esq_cima.
        cur[0] = 1'b0; repeat (3) ciclo(cur);
        cur[0] = 1'b1; ciclo(cur);
        cur[0] = 1'b0; repeat (3) ciclo(cur);
        cur[0] = 1'b1; repeat (10) ciclo(cur);

        // Long hold on dir_cima: auto-repeat.
        cur[2] = 1'b0;
        repeat (36) ciclo(cur);
        cur[2] = 1'b1;
        repeat (10) ciclo(cur);

        // Paddle conflict on the left, right paddle held independently.
        cur[0] = 1'b0; cur[3] = 1'b0;
        repeat (5) ciclo(cur);
        cur[1] = 1'b0;
        repeat (20) ciclo(cur);
        cur[1] = 1'b1;
        repeat (25) ciclo(cur);
        cur[0] = 1'b1; cur[3] = 1'b1;
        repeat (10) ciclo(cur);

        // Button held across reset, mid-repeat.
        cur[2] = 1'b0;
        repeat (18) ciclo(cur);
        aplicar_reset(cur);
        repeat (20) ciclo(cur);
        cur[2] = 1'b1;
        repeat (10) ciclo(cur);

        // Randomized: per-bit hold times mixing glitches and long holds, rare resets.
        for (int b = 0; b < 6; b++) restante[b] = 0;
        repeat (3000) begin
            for (int b = 0; b < 6; b++) begin
                if (restante[b] == 0) begin
                    cur[b]     = ~cur[b];
                    restante[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                              : int'($urandom_range(5, 40));
                end
                restante[b]--;
            end
            if ($urandom_range(0, 499) == 0) aplicar_reset(cur);
            else ciclo(cur);
        end

        $display("[TB] %0d tests run, %0d failed", testes, falhas);
        $finish;
    end

endmodule

// File: doc/condicionador_botoes.md
# condicionador_botoes

Input-conditioning stage directly upstream of the Pong top level. Takes the six raw active-low board pushbuttons (four paddle buttons, pausa, iniciar) and synchronizes, debounces and inverts each one. Outputs clean active-high levels, single-cycle press pulses, and paddle-move pulses with auto-repeat. These outputs replace the direct `~botao` inversions that currently feed the datapath and control unit.

## Interface
- DEBOUNCE_CICLOS, 50000: consecutive stable cycles required to accept a level change (1 ms at 50 MHz); ≥1
- REPEAT_ATRASO, 15000000: cycles from initial press pulse to first auto-repeat move pulse; ≥2
- REPEAT_PERIODO, 5000000: cycles between subsequent auto-repeat move pulses; ≥1

- clock  in  1  system clock; single clock domain
- reset  in  1  asynchronous, active-low reset
- botoes_n  in  6  raw buttons, active-low, asynchronous to clock; bit order [0] esquerdo_cima, [1] esquerdo_baixo, [2] direito_cima, [3] direito_baixo, [4] pausa, [5] iniciar
- nivel  out  6  debounced level, active-high, same bit order
- pulso  out  6  one-cycle pulse on each accepted press (0→1 of nivel)
- mover  out  4  paddle-move pulses for bits [3:0]: press pulse plus auto-repeat, with conflict suppression

## Operation
- Per bit: 2-flop synchronizer (flops reset to 1, meaning released), then debounce FSM:
  - States: SOLTO, CONFIRMA_PRESS, PRESSIONADO, CONFIRMA_SOLTA.
  - SOLTO→CONFIRMA_PRESS when the synced input reads pressed.
  - CONFIRMA_PRESS→PRESSIONADO after DEBOUNCE_CICLOS consecutive pressed samples; back to SOLTO on any released sample (counter cleared).
  - PRESSIONADO/CONFIRMA_SOLTA behave symmetrically for release.
- nivel = 1 in PRESSIONADO and CONFIRMA_SOLTA.
- pulso[i] is asserted for exactly the cycle in which nivel[i] rises. Releases produce no pulse.
- Debounce counter width is $clog2(DEBOUNCE_CICLOS+1). It saturates and never wraps.
- Auto-repeat applies per paddle bit i∈[3:0] and uses a counter of width $clog2(max(REPEAT_ATRASO,REPEAT_PERIODO)+1):
  - mover[i] is asserted with pulso[i].
  - While nivel[i] stays 1, further mover[i] pulses occur at t+REPEAT_ATRASO, then every REPEAT_PERIODO cycles, where t is the pulso cycle.
  - Release clears the counter immediately.
- Conflict rule: while both cima and baixo of the same paddle (bits 0/1 or 2/3) have nivel=1:
  - Both mover bits of that paddle are forced to 0, including pulses in the same cycle.
  - Both repeat counters are held at 0.
  - When one of the two is released, the remaining one restarts its repeat timing from 0. Its first move comes after REPEAT_ATRASO, with no immediate pulse.
- Conflict between paddles is independent per paddle.
- pausa/iniciar (bits 4, 5) have no auto-repeat and no mover output.

## Timing
- Reset (reset=0) asynchronously sets: nivel=0, pulso=0, mover=0, FSMs in SOLTO, all counters 0, synchronizer flops 1.
- Latency: a raw edge before clock edge k produces a nivel/pulso change at edge k+1+DEBOUNCE_CICLOS, i.e. DEBOUNCE_CICLOS+2 edges.
- All outputs are registered; no combinational path from botoes_n to any output.
- Button held through reset release: after reset deasserts it is treated as a new press (pulso after DEBOUNCE_CICLOS+2 edges).
- Reset asserted mid-debounce or mid-repeat: everything is abandoned; no pulse is emitted on exit.
- Glitch shorter than DEBOUNCE_CICLOS cycles in either direction: no change to nivel, no pulse.
- Simultaneous presses on different bits are fully independent, except for the conflict rule.

## Structure
- Shared package pong_pkg holds:
  - Bit-index constants BTN_ESQ_CIMA=0, BTN_ESQ_BAIXO=1, BTN_DIR_CIMA=2, BTN_DIR_BAIXO=3, BTN_PAUSA=4, BTN_INICIAR=5.
  - The debounce FSM state encoding.
  - Default timing constants.
- Sub-module debounce_botao (synchronizer + FSM + counter, outputs nivel and pulso) is instantiated 6 times.
- Auto-repeat and conflict logic live in the parent condicionador_botoes.

## Test plan
Use DEBOUNCE_CICLOS=4, REPEAT_ATRASO=8, REPEAT_PERIODO=3.
- Clean press on bit 4, held 20 cycles: nivel[4] rises 6 edges after the raw edge; pulso[4] high exactly 1 cycle; mover unchanged; release → nivel[4] falls 6 edges later with no pulse.
- Bounce on bit 0 (pressed 3 cycles, released 1, pressed 3, released): nivel/pulso/mover stay 0 throughout.
- Hold bit 2 for 30 cycles after acceptance: mover[2] pulses at t, t+8, t+11, t+14, …, t+29; release → no further pulses.
- Bit 0 accepted, then bit 1 accepted 5 cycles later: mover[1:0]=0 while both are held; release bit 1 → mover[0] next at +8, then every 3 cycles; paddle 2 unaffected.
- Button held across reset: reset=0 mid-repeat → all outputs 0 immediately; reset=1 → pulso and mover fire again 6 edges later.
